// File: rtl/cpu_sayac_traffic_gen_if.sv
// SAYAC bus handshake: rd/wr requests from the master, ready strobe from memory.
interface cpu_sayac_traffic_gen_if;
    logic rd;
    logic wr;
    logic ready;

    modport master (output rd, output wr, input ready);
    modport slave  (input rd, input wr, output ready);
endinterface

// File: rtl/cpu_sayac_traffic_gen.sv
// Script-driven SAYAC bus master: replays WRITE/READ/READ_CHECK/NOP entries for N passes,
// checks read data, counts mismatches and aborts on a bus timeout.
module cpu_sayac_traffic_gen #(
    parameter int  DATA_WIDTH     = 16,
    parameter int  ADR_WIDTH      = 16,
    parameter int  NUM_OPS        = 32,
    parameter int  TIMEOUT_CYCLES = 64,
    parameter int  ERR_WIDTH      = 8,
    localparam int IDX_W          = $clog2(NUM_OPS),
    localparam int CMD_W          = 2 + ADR_WIDTH + DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_addr,
    input  logic [CMD_W-1:0]      cfg_cmd,
    input  logic [IDX_W:0]        script_len,
    input  logic [7:0]            passes,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [IDX_W-1:0]      first_err_idx,
    output logic [DATA_WIDTH-1:0] last_read_data,
    output wire  [ADR_WIDTH-1:0]  address_bus,
    inout  wire  [DATA_WIDTH-1:0] data_bus,
    cpu_sayac_traffic_gen_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_CHK = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_NOP, S_DONE} state_t;

    state_t                r_state, w_state_next;
    logic [IDX_W-1:0]      r_idx, w_idx_next;
    logic [7:0]            r_pass, w_pass_next;
    logic [TW-1:0]         r_tcnt;
    logic                  r_rd, r_wr, w_rd_next, w_wr_next;
    logic                  r_busy, r_done, r_timeout;
    logic [ERR_WIDTH-1:0]  r_err;
    logic [IDX_W-1:0]      r_first_err;
    logic [DATA_WIDTH-1:0] r_last_rd;
    logic                  w_start, w_complete, w_abort, w_finish;

    logic [CMD_W-1:0]      r_script [NUM_OPS];
    logic [CMD_W-1:0]      r_entry;

    logic [1:0]            w_op;
    logic [ADR_WIDTH-1:0]  w_adr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [IDX_W:0]        w_len, w_idx_inc;
    logic [8:0]            w_passes_eff, w_pass_inc;
    logic                  w_cfg_open;

    assign w_op   = r_entry[CMD_W-1 -: 2];
    assign w_adr  = r_entry[DATA_WIDTH +: ADR_WIDTH];
    assign w_data = r_entry[DATA_WIDTH-1:0];

    assign w_len        = (script_len > NUM_OPS[IDX_W:0]) ? NUM_OPS[IDX_W:0] : script_len;
    assign w_idx_inc    = {1'b0, r_idx} + (IDX_W+1)'(1);
    assign w_passes_eff = (passes == 8'd0) ? 9'd1 : {1'b0, passes};
    assign w_pass_inc   = {1'b0, r_pass} + 9'd1;
    assign w_cfg_open   = (r_state == S_IDLE) || (r_state == S_DONE);

    // Script store. The read address follows the next index so the entry is ready in ISSUE.
    always_ff @(posedge clk) begin
        if (cfg_we && w_cfg_open)
            r_script[cfg_addr] <= cfg_cmd;
        r_entry <= r_script[w_idx_next];
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_pass_next  = r_pass;
        w_rd_next    = 1'b0;
        w_wr_next    = 1'b0;
        w_start      = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_start      = 1'b1;
                    w_idx_next   = '0;
                    w_pass_next  = '0;
                    w_state_next = (w_len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                case (w_op)
                    OP_NOP:  w_state_next = S_NOP;
                    OP_WR: begin
                        w_wr_next    = 1'b1;
                        w_state_next = S_WAIT;
                    end
                    default: begin
                        w_rd_next    = 1'b1;
                        w_state_next = S_WAIT;
                    end
                endcase
            end
            S_WAIT: begin
                w_rd_next = r_rd;
                w_wr_next = r_wr;
                if (bus.ready) begin
                    w_complete   = 1'b1;
                    w_rd_next    = 1'b0;
                    w_wr_next    = 1'b0;
                    w_state_next = S_GAP;
                end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_abort      = 1'b1;
                    w_rd_next    = 1'b0;
                    w_wr_next    = 1'b0;
                    w_state_next = S_DONE;
                end
            end
            S_GAP, S_NOP: begin
                if (w_idx_inc < w_len) begin
                    w_idx_next   = r_idx + IDX_W'(1);
                    w_state_next = S_ISSUE;
                end else if (w_pass_inc < w_passes_eff) begin
                    w_idx_next   = '0;
                    w_pass_next  = r_pass + 8'd1;
                    w_state_next = S_ISSUE;
                end else begin
                    w_finish     = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_pass      <= '0;
            r_tcnt      <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err       <= '0;
            r_first_err <= '0;
            r_last_rd   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_pass  <= w_pass_next;
            r_rd    <= w_rd_next;
            r_wr    <= w_wr_next;
            r_tcnt  <= (r_state == S_WAIT && w_state_next == S_WAIT) ? r_tcnt + TW'(1) : '0;
            if (w_start) begin
                r_busy      <= (w_len != '0);
                r_done      <= (w_len == '0);
                r_timeout   <= 1'b0;
                r_err       <= '0;
                r_first_err <= '0;
            end
            // The error counter is zero exactly until the first mismatch since it never wraps.
            if (w_complete && r_rd) begin
                r_last_rd <= data_bus;
                if (w_op == OP_CHK && data_bus != w_data) begin
                    if (r_err != '1)
                        r_err <= r_err + ERR_WIDTH'(1);
                    if (r_err == '0)
                        r_first_err <= r_idx;
                end
            end
            if (w_abort) begin
                r_timeout <= 1'b1;
                r_busy    <= 1'b0;
            end
            if (w_finish) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign bus.rd         = r_rd;
    assign bus.wr         = r_wr;
    assign address_bus    = (r_rd || r_wr) ? w_adr : 'z;
    assign data_bus       = r_wr ? w_data : 'z;
    assign busy           = r_busy;
    assign done           = r_done;
    assign timeout        = r_timeout;
    assign err_count      = r_err;
    assign first_err_idx  = r_first_err;
    assign last_read_data = r_last_rd;
endmodule
